op_sequencer: RTL and testbench

- Command-queue front end for the 4-bank matrix controller.
- Accepts 32-bit operation words from a host over a valid/ready handshake and buffers them in a small FIFO.
- Drives the controller's operation bus, holding each operation for exactly the number of cycles it needs. Serial page writes and reads are streamed through to the controller; an idle gap is inserted between operations so the controller sees a fresh rising edge of opcode 1.

---
 rtl/op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_op_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - command FIFO and operation-bus sequencer for the 4-bank matrix controller
module op_sequencer #(
  parameter int DEPTH      = 4,
  parameter int MM_CYCLES  = 160,
  parameter int PAGE_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] cmd_op,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] operation,
  output logic [31:0] ctl_in_data,
  input  logic [31:0] ctl_out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (MM_CYCLES > PAGE_WORDS) ? MM_CYCLES : PAGE_WORDS;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] MM_LAST = CW'(MM_CYCLES - 1);
  localparam logic [CW-1:0] PG_LAST = CW'(PAGE_WORDS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATMUL,
    S_WRITE,
    S_READ,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [31:0]   cur_op_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          wr_beat;
  logic [31:0]   head;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = enable && cmd_valid && !fifo_full;
  assign pop        = enable && (state_q == S_IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  assign cmd_ready  = enable && !fifo_full;
  assign wr_ready   = enable && (state_q == S_WRITE);
  assign wr_beat    = wr_ready && wr_valid;
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

  // Write beats reach the controller only when accepted, so a stall shows an idle bus.
  always_comb begin
    operation   = '0;
    ctl_in_data = '0;
    case (state_q)
      S_MATMUL, S_READ: operation = cur_op_q;
      S_WRITE: begin
        if (wr_beat) begin
          operation   = cur_op_q;
          ctl_in_data = wr_data;
        end
      end
      default: operation = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cur_op_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (enable) begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_op_q <= head;
            cnt_q    <= '0;
            case (head[3:0])
              4'd0:    state_q <= S_IDLE;
              4'd1:    state_q <= S_MATMUL;
              4'd2:    state_q <= S_WRITE;
              4'd3:    state_q <= S_READ;
              default: err_q   <= 1'b1;
            endcase
          end
        end
        S_MATMUL: begin
          if (cnt_q == MM_LAST) begin
            state_q <= S_GAP;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            if (cnt_q == PG_LAST) begin
              state_q <= S_GAP;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_READ: begin
          rd_data_q  <= ctl_out_data;
          rd_valid_q <= 1'b1;
          if (cnt_q == PG_LAST) begin
            state_q <= S_GAP;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - scoreboard bench for op_sequencer
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cmd_op;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] operation;
  logic [31:0] ctl_in_data;
  logic [31:0] ctl_out_data;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [63:0] op_q[$];
  logic [31:0] rd_q[$];
  int          exp_done = 0;
  int          exp_err  = 0;
  bit          ign_ops  = 1'b0;
  logic [63:0] mon_e;
  logic [31:0] mon_r;
  logic [31:0] n0;

  op_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .operation(operation), .ctl_in_data(ctl_in_data), .ctl_out_data(ctl_out_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign ctl_out_data = {16'hC0DE, cyc[15:0]};

  // Monitor: inputs change just after posedge, so mid-cycle samples pair state with its inputs.
  always @(negedge clk) begin
    if (!ign_ops && operation != 32'd0) begin
      checks++;
      if (op_q.size() == 0) begin
        errors++;
        $display("FAIL op_unexpected: operation=%h in_data=%h, expected idle bus", operation, ctl_in_data);
      end else begin
        mon_e = op_q.pop_front();
        if (operation != mon_e[63:32] || (mon_e[35:32] == 4'd2 && ctl_in_data != mon_e[31:0])) begin
          errors++;
          $display("FAIL op_seq: operation=%h in_data=%h, expected operation=%h in_data=%h",
                   operation, ctl_in_data, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
    if (rd_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_data=%h, expected no rd_valid", rd_data);
      end else begin
        mon_r = rd_q.pop_front();
        if (rd_data != mon_r) begin
          errors++;
          $display("FAIL rd_seq: rd_data=%h, expected %h", rd_data, mon_r);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done == 0 || operation != 32'd0) begin
        errors++;
        $display("FAIL done_pulse: done=1 operation=%h pending=%0d, expected pending>0 and operation=0", operation, exp_done);
      end else begin
        exp_done--;
      end
    end
    if (err) begin
      checks++;
      if (exp_err == 0) begin
        errors++;
        $display("FAIL err_pulse: err=1, expected 0");
      end else begin
        exp_err--;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mm(input logic [31:0] op);
    for (int i = 0; i < 160; i++) op_q.push_back({op, 32'd0});
    exp_done++;
  endtask

  task automatic push(input logic [31:0] v);
    int t = 0;
    @(posedge clk); #1;
    cmd_op = v; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && t < 2000) begin
      @(posedge clk); #2; t++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=0, expected 1 within 2000 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (busy && t < 3000);
    chk("busy_falls", {31'd0, busy}, 32'd0);
  endtask

  task automatic write_stream(input int freeze_at);
    int k = 0;
    int t = 0;
    bit frozen = 1'b0;
    while (k < 64 && t < 1000) begin
      @(posedge clk); #1; t++;
      if (k == freeze_at && !frozen) begin
        frozen = 1'b1;
        enable = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
        repeat (10) begin
          #1;
          chk("frz_wr_ready", {31'd0, wr_ready}, 32'd0);
          chk("frz_operation", operation, 32'd0);
          chk("frz_cmd_ready", {31'd0, cmd_ready}, 32'd0);
          chk("frz_busy", {31'd0, busy}, 32'd1);
          @(posedge clk); #1;
        end
        enable = 1'b1;
      end
      wr_data  = k;
      wr_valid = (t % 4 != 0);
      #1;
      if (wr_valid && wr_ready) k++;
    end
    chk("write_beats", k, 32'd64);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; cmd_op = '0; cmd_valid = 1'b0; wr_data = '0; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_operation", operation, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_in_data", ctl_in_data, 32'd0);
    reset = 1'b1;

    exp_mm(32'h0000_3221);
    push(32'h0000_3221);
    wait_idle();

    for (int k = 0; k < 64; k++) op_q.push_back({32'h0000_0012, 32'(k)});
    exp_done++;
    push(32'h0000_0012);
    write_stream(-1);
    wait_idle();

    exp_done++;
    push(32'h0000_0013);
    n0 = cyc;
    for (int k = 0; k < 64; k++) begin
      op_q.push_back({32'h0000_0013, 32'd0});
      rd_q.push_back(32'hC0DE_0000 | ((n0 + 32'd1 + 32'(k)) & 32'h0000_FFFF));
    end
    wait_idle();

    for (int i = 1; i <= 6; i++) exp_mm(32'h0000_0001 | (32'(i) << 8));
    for (int i = 1; i <= 5; i++) push(32'h0000_0001 | (32'(i) << 8));
    @(posedge clk); #1;
    cmd_op = 32'h0000_0601; cmd_valid = 1'b1;
    #1;
    chk("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
    push(32'h0000_0601);
    wait_idle();

    exp_err++;
    exp_mm(32'h0000_0051);
    push(32'h0000_0007);
    push(32'h0000_0000);
    push(32'h0000_0051);
    wait_idle();

    for (int k = 0; k < 64; k++) op_q.push_back({32'h0000_0022, 32'(k)});
    exp_done++;
    push(32'h0000_0022);
    write_stream(20);
    wait_idle();

    ign_ops = 1'b1;
    push(32'h0000_0061);
    push(32'h0000_0071);
    push(32'h0000_0081);
    repeat (44) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_operation", operation, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    ign_ops = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_operation", operation, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("op_q_drained", op_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("done_all_seen", exp_done, 32'd0);
    chk("err_all_seen", exp_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
